data_mem_responder: RTL and testbench

- Memory-side responder for the control unit's load/store path. The control unit issues requests; this block answers them.
- Holds a word-organised, little-endian data RAM.
- Accepts one load or store request at a time over a valid/ready handshake.
- Performs byte/half/word lane alignment with sign or zero extension, and returns a response after a configurable wait latency.

---
 rtl/mem_if_pkg.sv | 7 +
 rtl/mem_lane_align.sv | 28 ++
 rtl/data_mem_responder.sv | 93 +++++++++
 tb/tb_data_mem_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared size encodings and responder FSM states for the data memory path
package mem_if_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane strobes/positioning for stores and lane extraction with extension for loads
module mem_lane_align
  import mem_if_pkg::*;
(
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o
);
  logic [15:0] half;
  logic [7:0]  byte_l;
  always_comb begin
    strb_o  = size_i == SZ_BYTE ? 4'b0001 << addr_lo_i :
              size_i == SZ_HALF ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) :
              size_i == SZ_WORD ? 4'b1111 : 4'b0000;
    // replicating the data lets the strobe alone pick the destination lane
    wlane_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
              size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    half    = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    byte_l  = addr_lo_i[0] ? half[15:8] : half[7:0];
    rdata_o = size_i == SZ_BYTE ? {{24{~unsigned_i & byte_l[7]}}, byte_l} :
              size_i == SZ_HALF ? {{16{~unsigned_i & half[15]}}, half} : rword_i;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder over a word-organised little-endian RAM
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY == 0 ? 0 : LATENCY - 1);
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);
  state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic [31:0] rword, wlane, lrd;
  logic [3:0]  strb;
  logic        err, accept;
  assign idx    = req_addr[IW+1:2];
  assign rword  = mem_q[idx];
  assign accept = req_valid && state_q == IDLE;
  assign err    = req_size == 2'b11 ||
                  (req_size == SZ_HALF && req_addr[0]) ||
                  (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
                  {2'b00, req_addr[ADDR_W-1:2]} >= DEPTH_L;
  mem_lane_align u_align (
    .wdata_i   (req_wdata),
    .rword_i   (rword),
    .addr_lo_i (req_addr[1:0]),
    .size_i    (req_size),
    .unsigned_i(req_unsigned),
    .strb_o    (strb),
    .wlane_o   (wlane),
    .rdata_o   (lrd)
  );
  // stores commit on the accepting edge so any later load sees them
  always_ff @(posedge clk)
    if (accept && req_we && !err)
      for (int i = 0; i < 4; i++)
        if (strb[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = LATENCY == 0 ? RESP : WAIT;
        cnt_d   = LAT_M1;
        rdata_d = req_we || err ? 32'h0 : lrd;
        err_d   = err;
      end
      WAIT: begin
        state_d = cnt_q == 4'd0 ? RESP : WAIT;
        cnt_d   = cnt_q - 4'd1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed load/store vectors checked against a byte-addressed reference model
module tb_data_mem_responder;
  localparam int LAT = 2;
  localparam int DEPTH = 1024;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_we = 0, req_unsigned = 0, rsp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_size = 0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int n_chk = 0, n_fail = 0;

  data_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // reference model: byte-addressed memory plus one outstanding transaction
  logic [7:0]  mdl [int];
  bit          pending = 0;
  int          cyc = 0, acc = 0;
  logic [31:0] exp_rd = 0;
  logic        exp_err = 0;

  function automatic void model_accept(input logic we, input logic [31:0] a, input logic [1:0] sz,
                                       input logic u, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    exp_err = sz == 2'd3 || (a % n) != 0 || (a / 4) >= DEPTH;
    exp_rd = 0;
    if (exp_err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mdl[int'(a) + i] = wd[8*i +: 8];
      return;
    end
    v = 0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[int'(a) + i];
    if (!u && n == 1 && v[7]) v = v | 32'hFFFF_FF00;
    if (!u && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    exp_rd = v;
  endfunction

  function automatic bit exp_valid();
    return pending && cyc >= acc + LAT;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pending = 0;
    else begin
      if (exp_valid()) begin
        if (rsp_ready) pending = 0;
      end else if (!pending && req_valid) begin
        model_accept(req_we, req_addr, req_size, req_unsigned, req_wdata);
        pending = 1;
        acc = cyc + 1;
      end
      cyc++;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      chk("cmp_req_ready", 32'(req_ready), 32'(!pending));
      chk("cmp_rsp_valid", 32'(rsp_valid), 32'(exp_valid()));
      if (exp_valid()) begin
        chk("cmp_rsp_rdata", rsp_rdata, exp_rd);
        chk("cmp_rsp_err", 32'(rsp_err), 32'(exp_err));
      end
    end

  task automatic drive(input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd);
    req_valid = 1; req_we = we; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic xact(input string name, input logic we, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
    int lat;
    @(negedge clk);
    drive(we, a, sz, u, wd);
    @(negedge clk);
    req_valid = 0;
    wait_rsp(lat);
    chk({name, "_lat"}, 32'(lat + 1), 32'(LAT + 1));
    chk({name, "_rdata"}, rsp_rdata, erd);
    chk({name, "_err"}, 32'(rsp_err), 32'(eerr));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r0;
    logic        e0;
    int          lat;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    // reset while the FSM sits in WAIT
    @(negedge clk);
    drive(1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    req_valid = 0;
    chk("wait_req_ready", 32'(req_ready), 32'd0);
    #2 rst_n = 0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("inrst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("postrst_req_ready", 32'(req_ready), 32'd1);

    xact("sw100",     1, 32'h100, 2'b10, 0, 32'hDEADBEEF, 32'h0,        0);
    xact("lw100_a",   0, 32'h100, 2'b10, 0, 32'h0,        32'hDEADBEEF, 0);
    xact("sb101",     1, 32'h101, 2'b00, 0, 32'h000000A5, 32'h0,        0);
    xact("lw100_b",   0, 32'h100, 2'b10, 0, 32'h0,        32'hDEADA5EF, 0);
    xact("lb101",     0, 32'h101, 2'b00, 0, 32'h0,        32'hFFFFFFA5, 0);
    xact("lbu101",    0, 32'h101, 2'b00, 1, 32'h0,        32'h000000A5, 0);
    xact("lh102",     0, 32'h102, 2'b01, 0, 32'h0,        32'hFFFFDEAD, 0);
    xact("lhu102",    0, 32'h102, 2'b01, 1, 32'h0,        32'h0000DEAD, 0);
    xact("sh100",     1, 32'h100, 2'b01, 0, 32'h00001234, 32'h0,        0);
    xact("lw100_c",   0, 32'h100, 2'b10, 0, 32'h0,        32'hDEAD1234, 0);
    xact("lw102_mis", 0, 32'h102, 2'b10, 0, 32'h0,        32'h0,        1);
    xact("sw103_mis", 1, 32'h103, 2'b10, 0, 32'hFFFFFFFF, 32'h0,        1);
    xact("lw100_d",   0, 32'h100, 2'b10, 0, 32'h0,        32'hDEAD1234, 0);
    xact("lw1000_oor",0, 32'h1000,2'b10, 0, 32'h0,        32'h0,        1);
    xact("sb1000_oor",1, 32'h1000,2'b00, 0, 32'h5A,       32'h0,        1);
    xact("sz11",      0, 32'h100, 2'b11, 0, 32'h0,        32'h0,        1);
    xact("lh101_mis", 0, 32'h101, 2'b01, 0, 32'h0,        32'h0,        1);
    xact("lb103",     0, 32'h103, 2'b00, 0, 32'h0,        32'hFFFFFFDE, 0);

    // backpressure on the response with a competing request waiting
    @(negedge clk);
    rsp_ready = 0;
    drive(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    req_valid = 0;
    wait_rsp(lat);
    r0 = rsp_rdata;
    e0 = rsp_err;
    chk("hold_first_rdata", r0, 32'hDEAD1234);
    drive(1'b0, 32'h101, 2'b00, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, r0);
      chk("hold_err", 32'(rsp_err), 32'(e0));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 0;
    chk("pend_accepted", 32'(req_ready), 32'd0);
    wait_rsp(lat);
    chk("pend_rdata", rsp_rdata, 32'h00000012);
    chk("pend_err", 32'(rsp_err), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
